// File: rtl/nco_demod_pkg.sv
// Shared widths, FSM encoding and output reduction for the coherent I/Q demodulator.
// NCO_DEMOD_SAT_EN selects saturation instead of wrap-around at the symbol output.
package nco_demod_pkg;

  localparam int MPR   = 13;
  localparam int CW    = 8;
  localparam int SHIFT = 12;
  localparam int OPW   = 16;
  localparam int PW    = 2 * MPR;
  localparam int ACCW  = 2 * MPR + CW;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  // Symmetric limit +/-(2^(OPW-1)-1), held at accumulator width for signed compares.
  function automatic logic signed [ACCW-1:0] sat_limit();
    return $signed({{(ACCW-OPW+1){1'b0}}, {(OPW-1){1'b1}}});
  endfunction

  function automatic logic sym_saturates(input logic signed [ACCW-1:0] v);
    logic signed [ACCW-1:0] lim;
    lim = sat_limit();
    if ((v > lim) || (v < -lim)) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

  function automatic logic signed [OPW-1:0] reduce_sym(input logic signed [ACCW-1:0] v);
    logic signed [ACCW-1:0] res;
`ifdef NCO_DEMOD_SAT_EN
    logic signed [ACCW-1:0] lim;
    lim = sat_limit();
    if (v > lim) begin
      res = lim;
    end else if (v < -lim) begin
      res = -lim;
    end else begin
      res = v;
    end
`else
    res = v;
`endif
    return $signed(res[OPW-1:0]);
  endfunction

endpackage

// File: rtl/nco_demod_mac.sv
// One demodulator channel: registered product, integrate, and dump of the scaled symbol.
// NCO_DEMOD_SAT_EN adds the registered saturation flag; otherwise ovf is constant 0.
module nco_demod_mac
  import nco_demod_pkg::*;
#(
  parameter bit negate = 1'b0,
  parameter int shift  = SHIFT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clken,
  input  logic                   accept,
  input  logic                   last,
  input  logic                   clear,
  input  logic signed [MPR-1:0]  sample,
  input  logic signed [MPR-1:0]  coef,
  output logic signed [OPW-1:0]  sym,
  output logic                   ovf
);

  logic signed [PW-1:0]   raw;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   p;
  logic                   p_valid;
  logic                   p_last;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] sum;
  logic signed [ACCW-1:0] shifted;

  always_comb begin
    raw = $signed({{MPR{sample[MPR-1]}}, sample}) * $signed({{MPR{coef[MPR-1]}}, coef});
    if (negate) begin
      prod = -raw;
    end else begin
      prod = raw;
    end
    sum     = acc + $signed({{CW{p[PW-1]}}, p});
    shifted = sum >>> shift;
  end

  // A dump already in the product stage wins over an abort so the symbol still completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p       <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      acc     <= '0;
      sym     <= '0;
    end else if (clken) begin
      p_valid <= accept;
      p_last  <= accept & last;
      if (accept) begin
        p <= prod;
      end
      if (p_valid && p_last) begin
        acc <= '0;
        sym <= reduce_sym(shifted);
      end else if (clear) begin
        acc <= '0;
      end else if (p_valid) begin
        acc <= sum;
      end
    end
  end

`ifdef NCO_DEMOD_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (clken) begin
      ovf <= p_valid & p_last & sym_saturates(shifted);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/nco_iq_demod.sv
// Coherent I/Q integrate-and-dump demodulator fed by the sin/cos NCO.
// NCO_DEMOD_SAT_EN enables output saturation and the ovf_o flag.
module nco_iq_demod
  import nco_demod_pkg::*;
#(
  parameter int mpr   = MPR,
  parameter int cw    = CW,
  parameter int shift = SHIFT,
  parameter int opw   = OPW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic signed [mpr-1:0] sample_i,
  input  logic                  sample_valid,
  input  logic signed [mpr-1:0] fsin_i,
  input  logic signed [mpr-1:0] fcos_i,
  input  logic                  nco_valid,
  input  logic [cw-1:0]         sym_len_i,
  output logic signed [opw-1:0] i_o,
  output logic signed [opw-1:0] q_o,
  output logic                  sym_valid_o,
  output logic                  ovf_o
);

  localparam logic [cw-1:0] len_one  = {{(cw-1){1'b0}}, 1'b1};
  localparam logic [cw-1:0] len_zero = {cw{1'b0}};

  logic [0:0]    state;
  logic [0:0]    next_state;
  logic [cw-1:0] count;
  logic [cw-1:0] len_r;
  logic [cw-1:0] len_eff;
  logic          accept;
  logic          clear;
  logic          last;
  logic          last_p;
  logic          ovf_i;
  logic          ovf_q;

  always_comb begin
    accept     = 1'b0;
    clear      = 1'b0;
    next_state = state;
    case (state)
      IDLE: begin
        if (nco_valid) begin
          next_state = ACCUM;
        end else begin
          next_state = IDLE;
        end
      end
      ACCUM: begin
        if (nco_valid) begin
          accept = clken & sample_valid;
        end else begin
          next_state = IDLE;
          clear      = clken;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The symbol length is sampled only on the first sample of a symbol; 0 behaves as 1.
  always_comb begin
    if (count == len_zero) begin
      if (sym_len_i == len_zero) begin
        len_eff = len_one;
      end else begin
        len_eff = sym_len_i;
      end
    end else begin
      len_eff = len_r;
    end
    last = (count == (len_eff - len_one));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= len_zero;
      len_r       <= len_zero;
      last_p      <= 1'b0;
      sym_valid_o <= 1'b0;
    end else if (clken) begin
      state       <= next_state;
      last_p      <= accept & last;
      sym_valid_o <= last_p;
      if (clear) begin
        count <= len_zero;
      end else if (accept) begin
        if (last) begin
          count <= len_zero;
        end else begin
          count <= count + len_one;
        end
      end
      if (accept && (count == len_zero)) begin
        len_r <= len_eff;
      end
    end
  end

  nco_demod_mac #(.negate(1'b0), .shift(shift)) u_mac_i (
    .clk    (clk),
    .rst    (reset),
    .clken  (clken),
    .accept (accept),
    .last   (last),
    .clear  (clear),
    .sample (sample_i),
    .coef   (fcos_i),
    .sym    (i_o),
    .ovf    (ovf_i)
  );

  nco_demod_mac #(.negate(1'b1), .shift(shift)) u_mac_q (
    .clk    (clk),
    .rst    (reset),
    .clken  (clken),
    .accept (accept),
    .last   (last),
    .clear  (clear),
    .sample (sample_i),
    .coef   (fsin_i),
    .sym    (q_o),
    .ovf    (ovf_q)
  );

  assign ovf_o = ovf_i | ovf_q;

endmodule
